// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//
// Program loader. It takes a length-prefixed, little-endian byte stream,
// packs the bytes into 32-bit words and writes them to consecutive word
// addresses of the instruction memory, starting at address 0. The CPU is
// held in reset (cpu_hold_o=1) until a load completes successfully.
//
// Stream: L, then 4*N data bytes (byte 0 of a word -> bits 7:0).
//         N = L, except L = 0 means N = DEPTH. L > DEPTH aborts with no writes.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   : one trailing byte must equal the XOR of L and all data
//               bytes, otherwise the load ends in ERR (memory not rolled back).
//   undefined : no checksum byte; the last write goes straight to DONE.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   start_i        one-cycle pulse that begins a load (ignored while busy)
//   byte_valid_i   source presents a byte on byte_data_i
//   byte_data_i    stream byte
//   byte_ready_o   loader accepts a byte this cycle
//   mem_we_o       instruction memory write strobe, one cycle per word
//   mem_addr_o     word address being written
//   mem_wdata_o    word being written
//   cpu_hold_o     high keeps the CPU in reset
//   busy_o         load in progress
//   done_o         load completed successfully (level)
//   err_o          load aborted (level)
//
// state | meaning
// IDLE  | after reset, waiting for start, CPU held
// LEN   | waiting for the length byte
// DATA  | collecting the 4 bytes of the current word
// WRITE | one-cycle memory write of the assembled word
// CHK   | waiting for the checksum byte (LOADER_CHECKSUM_EN only)
// DONE  | load complete, CPU released
// ERR   | load aborted, CPU held
// ---------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int ADDR_W = 6,
    parameter int WORD_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK   = 3'd4;
`endif
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    // Words still to be written; one bit wider than the address so that
    // a full-depth load (L = 0) fits.
    logic [ADDR_W:0]   words_q, words_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    logic accept;

    // All outputs are decoded from registered state or are registers.
    always_comb begin
        byte_ready_o = (state_q == S_LEN) || (state_q == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                       || (state_q == S_CHK)
`endif
                       ;
        busy_o       = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_WRITE)
`ifdef LOADER_CHECKSUM_EN
                       || (state_q == S_CHK)
`endif
                       ;
        mem_we_o     = (state_q == S_WRITE);
        done_o       = (state_q == S_DONE);
        err_o        = (state_q == S_ERR);
        cpu_hold_o   = (state_q != S_DONE);
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = word_q;
    assign accept      = byte_valid_i & byte_ready_o;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        words_d = words_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) state_d = S_LEN;
            end
            S_LEN: begin
                if (accept) begin
                    if (int'(byte_data_i) > DEPTH) begin
                        state_d = S_ERR;
                    end else begin
                        // L = 0 encodes a full-depth load.
                        words_d = (byte_data_i == 8'd0) ? (ADDR_W+1)'(DEPTH)
                                                        : (ADDR_W+1)'(byte_data_i);
                        addr_d  = '0;
                        cnt_d   = '0;
                        state_d = S_DATA;
`ifdef LOADER_CHECKSUM_EN
                        xor_d   = byte_data_i;
`endif
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    // Shift right so the first byte of the word ends in bits 7:0.
                    word_d = {byte_data_i, word_q[WORD_W-1:8]};
                    cnt_d  = cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    xor_d  = xor_q ^ byte_data_i;
`endif
                    if (cnt_q == 2'd3) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Address wraps to 0 after word DEPTH-1; the terminal count
                // ends the load on that same write.
                addr_d  = addr_q + ADDR_W'(1);
                words_d = words_q - (ADDR_W+1)'(1);
                if (words_q == (ADDR_W+1)'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) state_d = (byte_data_i == xor_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            words_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// ---------------------------------------------------------------------------
// Self-checking bench for instr_mem_loader. A stream-level model turns each
// byte stream into the list of (address, word) writes and the final outcome;
// a monitor compares every memory write against that list.
// ---------------------------------------------------------------------------
module tb_instr_mem_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic              byte_valid_i;
    logic [7:0]        byte_data_i;
    logic              byte_ready_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              cpu_hold_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    instr_mem_loader #(.ADDR_W(ADDR_W), .WORD_W(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .cpu_hold_o   (cpu_hold_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    int         checks = 0;
    int         errors = 0;
    wr_t        exp_q[$];
    logic [7:0] stream_q[$];
    int         n_writes = 0;
    int         exp_words;
    logic [7:0] exp_chk;
    bit         exp_ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Stream-level reference: parse the stream into expected writes and outcome.
    task automatic build_model();
        int l, n;
        exp_q.delete();
        l = int'(stream_q[0]);
        exp_chk = stream_q[0];
        if (l > DEPTH) begin
            exp_words = 0;
            exp_ok    = 1'b0;
            return;
        end
        n = (l == 0) ? DEPTH : l;
        exp_words = n;
        for (int k = 0; k < n; k++) begin
            wr_t w;
            w.addr = 6'(k % DEPTH);
            w.data = {stream_q[4*k+4], stream_q[4*k+3], stream_q[4*k+2], stream_q[4*k+1]};
            exp_q.push_back(w);
            for (int b = 1; b <= 4; b++) exp_chk = exp_chk ^ stream_q[4*k+b];
        end
        exp_ok = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        exp_ok = (stream_q[4*n+1] == exp_chk);
`endif
    endtask

    // Random stream of nw words (L = nw), data random or incrementing.
    task automatic make_stream(input int l, input int nw, input bit incr);
        logic [7:0] x;
        stream_q.delete();
        stream_q.push_back(8'(l));
        x = 8'(l);
        for (int i = 0; i < 4*nw; i++) begin
            logic [7:0] b;
            b = incr ? 8'(i) : 8'($urandom);
            stream_q.push_back(b);
            x = x ^ b;
        end
`ifdef LOADER_CHECKSUM_EN
        stream_q.push_back(x);
`endif
    endtask

    // Every cycle: memory writes against the model, plus output rules.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("we_while_ready", 32'(mem_we_o & byte_ready_o), 32'd0);
            check("hold_rule", 32'(cpu_hold_o), 32'(!done_o));
            if (mem_we_o) begin
                n_writes++;
                check("write_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("write_addr", 32'(mem_addr_o), 32'(w.addr));
                    check("write_data", mem_wdata_o, w.data);
                end
            end
        end
    end

    // Pulses start, then streams stream_q with gap_pct % idle cycles.
    // lat = edges from first acceptance to first cycle with done/err.
    // stop_at > 0 returns once that many bytes have been accepted.
    task automatic run_load(input int gap_pct, input int stop_at, input bit rand_start,
                            output int lat);
        int idx = 0;
        int n = 0;
        int budget = 0;
        bit started = 0;
        bit v, rdy;
        lat = -1;
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        while (budget < 20000) begin
            budget++;
            @(negedge clk_i);
            if (started && (done_o || err_o)) begin
                lat = n;
                break;
            end
            rdy = byte_ready_o;
            v = (idx < stream_q.size()) && ($urandom_range(0, 99) >= gap_pct);
            byte_valid_i = v;
            byte_data_i  = v ? stream_q[idx] : 8'($urandom);
            start_i      = rand_start && busy_o && ($urandom_range(0, 9) == 0);
            @(posedge clk_i);
            if (started) n++;
            if (v && rdy) begin
                if (!started) begin
                    started = 1;
                    n = 0;
                end
                idx++;
            end
            if (stop_at > 0 && idx == stop_at) break;
        end
        byte_valid_i = 1'b0;
        start_i      = 1'b0;
        if (stop_at == 0 && lat < 0) check("load_finished", 32'd0, 32'd1);
    endtask

    task automatic end_checks(input bit chk_addr);
        check("done",       32'(done_o),       32'(exp_ok));
        check("err",        32'(err_o),        32'(!exp_ok));
        check("cpu_hold",   32'(cpu_hold_o),   32'(!exp_ok));
        check("busy",       32'(busy_o),       32'd0);
        check("byte_ready", 32'(byte_ready_o), 32'd0);
        check("writes_left", 32'(exp_q.size()), 32'd0);
        if (chk_addr) check("final_addr", 32'(mem_addr_o), 32'(exp_words % DEPTH));
    endtask

    task automatic reset_checks();
        check("rst_byte_ready", 32'(byte_ready_o), 32'd0);
        check("rst_mem_we",     32'(mem_we_o),     32'd0);
        check("rst_mem_addr",   32'(mem_addr_o),   32'd0);
        check("rst_mem_wdata",  mem_wdata_o,       32'd0);
        check("rst_cpu_hold",   32'(cpu_hold_o),   32'd1);
        check("rst_busy",       32'(busy_o),       32'd0);
        check("rst_done",       32'(done_o),       32'd0);
        check("rst_err",        32'(err_o),        32'd0);
    endtask

    initial begin
        int lat, w0, extra;
`ifdef LOADER_CHECKSUM_EN
        extra = 1;
`else
        extra = 0;
`endif
        rst_i = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_data_i = 8'h00;
        repeat (3) @(negedge clk_i);
        reset_checks();
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // Directed two-word load.
        stream_q = '{8'h02, 8'h83, 8'h20, 8'h00, 8'h00, 8'h03, 8'h21, 8'h40, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        stream_q.push_back(8'hC3);
`endif
        build_model();
        check("model_word0", exp_q[0].data, 32'h00002083);
        check("model_word1", exp_q[1].data, 32'h00402103);
        check("model_chk", 32'(exp_chk), 32'h000000C3);
        w0 = n_writes;
        run_load(0, 0, 0, lat);
        end_checks(1);
        check("dir_writes", 32'(n_writes - w0), 32'd2);
        check("dir_load_time", 32'(lat + 1), 32'(1 + 5*2 + extra));

`ifdef LOADER_CHECKSUM_EN
        // Same stream, wrong checksum: writes happen, load ends in ERR.
        stream_q[9] = 8'h00;
        build_model();
        w0 = n_writes;
        run_load(0, 0, 0, lat);
        end_checks(1);
        check("badchk_err", 32'(err_o), 32'd1);
        check("badchk_writes", 32'(n_writes - w0), 32'd2);
`endif

        // L = 0: full-depth load with incrementing bytes.
        make_stream(0, DEPTH, 1);
        build_model();
        check("model_word63", exp_q[63].data, 32'hFFFEFDFC);
        check("model_addr63", 32'(exp_q[63].addr), 32'd63);
        w0 = n_writes;
        run_load(0, 0, 0, lat);
        end_checks(1);
        check("full_writes", 32'(n_writes - w0), 32'd64);
        check("full_addr_wrap", 32'(mem_addr_o), 32'd0);
        check("full_load_time", 32'(lat + 1), 32'(1 + 5*DEPTH + extra));

        // L > DEPTH: abort on the cycle after the length byte, no writes.
        stream_q = '{8'h41, 8'h11, 8'h22, 8'h33, 8'h44};
        build_model();
        w0 = n_writes;
        run_load(0, 0, 0, lat);
        end_checks(0);
        check("oversize_err_latency", 32'(lat), 32'd0);
        check("oversize_writes", 32'(n_writes - w0), 32'd0);

        // Same 3-word stream with and without 50% byte_valid gaps.
        make_stream(3, 3, 0);
        build_model();
        run_load(0, 0, 0, lat);
        end_checks(1);
        check("gapfree_load_time", 32'(lat + 1), 32'(1 + 5*3 + extra));
        build_model();
        w0 = n_writes;
        run_load(50, 0, 1, lat);
        end_checks(1);
        check("gap_writes", 32'(n_writes - w0), 32'd3);

        // Random lengths and gaps, spurious start pulses while busy.
        for (int r = 0; r < 8; r++) begin
            int l;
            l = $urandom_range(1, 12);
            make_stream(l, l, 0);
            build_model();
            run_load($urandom_range(0, 70), 0, 1, lat);
            end_checks(1);
        end

        // Reset after 6 data bytes of a 2-word load.
        make_stream(2, 2, 0);
        build_model();
        w0 = n_writes;
        run_load(30, 7, 0, lat);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        reset_checks();
        check("midrst_writes", 32'(n_writes - w0), 32'd1);
        check("midrst_pending", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        build_model();
        w0 = n_writes;
        run_load(0, 0, 0, lat);
        end_checks(1);
        check("restart_writes", 32'(n_writes - w0), 32'd2);

        repeat (3) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
